// File: rtl/mul_seq_pkg.sv
// mul_seq_pkg: shared constants and types for the RV32M multiply sequencer.
//   XLEN      - operand/result width
//   CHUNK     - rs2 bits consumed per accumulate cycle
//   NUM_STEPS - accumulate cycle count, ceil(XLEN/CHUNK)
//   mul_op_e  - 2-bit op encoding shared with the decoder
//   state_e   - sequencer state
package mul_seq_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned CHUNK     = 11;
  localparam int unsigned NUM_STEPS = (XLEN + CHUNK - 1) / CHUNK;
  localparam int unsigned STEP_W    = 2;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCUM  = 2'b01,
    ST_FINISH = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

endpackage

// File: rtl/mul_seq_fin.sv
// mul_seq_fin: final sign correction and result-word select.
//   i_acc   - unsigned magnitude product
//   i_neg   - product must be negated
//   i_upper - return the high word instead of the low word
//   o_word  - selected result word
module mul_seq_fin
  import mul_seq_pkg::*;
(
  input  logic [2*XLEN-1:0] i_acc,
  input  logic              i_neg,
  input  logic              i_upper,
  output logic [XLEN-1:0]   o_word
);

  logic [2*XLEN-1:0] w_prod;

  always_comb begin
    w_prod = i_neg ? (~i_acc + 64'd1) : i_acc;
    o_word = i_upper ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
  end

endmodule

// File: rtl/mul_seq.sv
// mul_seq: multi-cycle RV32M multiply sequencer (MUL, MULH, MULHSU, MULHU).
//   i_clk, i_rst_n              - clock, async active-low reset
//   i_req_valid / o_req_ready   - request handshake (one op in flight)
//   i_req_op, i_req_rs1/rs2     - operation and operands
//   i_req_tag                   - destination index echoed on the response
//   i_flush                     - abandon any in-flight operation
//   o_resp_valid / i_resp_ready - response handshake
//   o_resp_prod, o_resp_tag     - result word and its tag
//   o_busy                      - sequencer not idle
module mul_seq
  import mul_seq_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [1:0]      i_req_op,
  input  logic [XLEN-1:0] i_req_rs1,
  input  logic [XLEN-1:0] i_req_rs2,
  input  logic [4:0]      i_req_tag,
  input  logic            i_flush,
  output logic            o_resp_valid,
  input  logic            i_resp_ready,
  output logic [XLEN-1:0] o_resp_prod,
  output logic [4:0]      o_resp_tag,
  output logic            o_busy
);

  state_e              r_state;
  logic [2*XLEN-1:0]   r_acc;
  logic [STEP_W-1:0]   r_step;
  logic [XLEN-1:0]     r_mag1;
  logic [XLEN-1:0]     r_mag2;
  logic                r_neg;
  logic                r_upper;
  logic [4:0]          r_tag;

  mul_op_e             w_op;
  logic                w_s1;
  logic                w_s2;
  logic [XLEN-1:0]     w_mag1;
  logic [XLEN-1:0]     w_mag2;
  logic                w_zero;
  int unsigned         w_shamt;
  logic [CHUNK-1:0]    w_slice;
  logic [2*XLEN-1:0]   w_partial;
  logic [XLEN-1:0]     w_fin;

  // Operand decode; MUL takes the unsigned path since its low word is sign-independent.
  always_comb begin
    w_op   = mul_op_e'(i_req_op);
    w_s1   = i_req_rs1[XLEN-1] & ((w_op == MUL_OP_MULH) | (w_op == MUL_OP_MULHSU));
    w_s2   = i_req_rs2[XLEN-1] & (w_op == MUL_OP_MULH);
    w_mag1 = w_s1 ? (~i_req_rs1 + 32'd1) : i_req_rs1;
    w_mag2 = w_s2 ? (~i_req_rs2 + 32'd1) : i_req_rs2;
    w_zero = (i_req_rs1 == '0) | (i_req_rs2 == '0);
  end

  // One partial product per cycle; the last slice is short and its high bits shift in as 0.
  always_comb begin
    w_shamt   = 32'(r_step) * CHUNK;
    w_slice   = CHUNK'(r_mag2 >> w_shamt);
    w_partial = (64'(r_mag1) * 64'(w_slice)) << w_shamt;
  end

  mul_seq_fin u_fin (
    .i_acc   (r_acc),
    .i_neg   (r_neg),
    .i_upper (r_upper),
    .o_word  (w_fin)
  );

  assign o_req_ready = (r_state == ST_IDLE) && !i_flush;
  assign o_busy      = (r_state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_acc        <= '0;
      r_step       <= '0;
      r_mag1       <= '0;
      r_mag2       <= '0;
      r_neg        <= 1'b0;
      r_upper      <= 1'b0;
      r_tag        <= '0;
      o_resp_valid <= 1'b0;
      o_resp_prod  <= '0;
      o_resp_tag   <= '0;
    end else if (i_flush) begin
      // Result discarded; prod/tag keep their last values.
      r_state      <= ST_IDLE;
      o_resp_valid <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (i_req_valid) begin
            r_mag1  <= w_mag1;
            r_mag2  <= w_mag2;
            r_neg   <= w_s1 ^ w_s2;
            r_upper <= (w_op != MUL_OP_MUL);
            r_tag   <= i_req_tag;
            r_acc   <= '0;
            r_step  <= '0;
            r_state <= w_zero ? ST_FINISH : ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_acc  <= r_acc + w_partial;
          r_step <= r_step + 1'b1;
          if (r_step == STEP_W'(NUM_STEPS - 1)) r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          o_resp_prod  <= w_fin;
          o_resp_tag   <= r_tag;
          o_resp_valid <= 1'b1;
          r_state      <= ST_RESP;
        end
        ST_RESP: begin
          if (i_resp_ready) begin
            o_resp_valid <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mul_seq.md
Name: mul_seq

Overview:
- Multi-cycle sequencer for RV32M multiplies: MUL, MULH, MULHSU, MULHU.
- Accepts one request at a time from the execute stage over a valid/ready handshake.
- Converts operands to magnitudes and accumulates rs2 in CHUNK-bit slices into a 64-bit accumulator, one slice per cycle.
- Sign-corrects the product, selects the low or high word, and holds the result on a valid/ready response port until writeback takes it.

Parameters:
- XLEN, 32, operand/result width.
- CHUNK, 11, rs2 bits consumed per accumulate cycle.
- NUM_STEPS, ceil(XLEN/CHUNK) = 3, derived accumulate cycle count; not overridable.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  request accepted when REQ_VALID && REQ_READY at the rising edge.
- REQ_OP  in  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- REQ_RS1  in  XLEN  operand rs1.
- REQ_RS2  in  XLEN  operand rs2.
- REQ_TAG  in  5  destination register index, returned unchanged with the result.
- FLUSH  in  1  pipeline kill; abandons any in-flight operation.
- RESP_VALID  out  1  result valid.
- RESP_READY  in  1  consumer accepts result.
- RESP_PROD  out  XLEN  result word.
- RESP_TAG  out  5  tag of the result.
- BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RST_N low):
  - State IDLE.
  - RESP_VALID=0, RESP_PROD=0, RESP_TAG=0, BUSY=0.
  - Accumulator, step counter and operand registers cleared.
- States: IDLE, ACCUM, FINISH, RESP.
- REQ_READY = (state==IDLE) && !FLUSH. Only one operation is in flight; there is no request/response overlap.
- Operand decode at accept:
  - s1 = REQ_RS1[31] for MULH/MULHSU, else 0.
  - s2 = REQ_RS2[31] for MULH only.
  - mag1 = s1 ? -rs1 : rs1; mag2 likewise (32-bit unsigned). For 0x80000000 this gives 2^31, which is correct.
  - neg = s1 ^ s2.
  - upper = (REQ_OP != 00).
  - MUL always uses the unsigned path: its low word is sign-independent.
  - Latch tag. Clear accumulator and step counter.
- IDLE -> ACCUM on accept.
- Zero fast path: if REQ_RS1==0 or REQ_RS2==0 at accept, go IDLE -> FINISH and skip ACCUM.
- ACCUM, each cycle:
  - acc += ({32'b0, mag1} * mag2[step*CHUNK +: CHUNK]) << (step*CHUNK). The final slice is XLEN-(NUM_STEPS-1)*CHUNK = 10 bits; bits beyond XLEN read as 0.
  - step++.
  - After the step == NUM_STEPS-1 update, go to FINISH.
- FINISH (one cycle):
  - p = neg ? (~acc + 1) : acc.
  - RESP_PROD <= upper ? p[63:32] : p[31:0].
  - RESP_TAG <= latched tag. RESP_VALID <= 1. Go to RESP.
- RESP:
  - RESP_PROD and RESP_TAG are held stable while RESP_VALID && !RESP_READY.
  - On RESP_READY: RESP_VALID <= 0, go to IDLE. REQ_READY rises the following cycle.
- Latency, counted from the accept edge to the edge that sets RESP_VALID:
  - NUM_STEPS+1 = 4 cycles normally.
  - 1 cycle on the zero fast path.
- FLUSH (any state):
  - Next edge returns to IDLE with RESP_VALID=0. The result is discarded and no response is issued.
  - FLUSH wins over a simultaneous RESP_READY handshake and over a new request.
  - RESP_PROD and RESP_TAG keep their last values; they are don't-care while RESP_VALID=0.
- Reset mid-operation: immediate return to the reset values; no response is produced afterwards.
- Arithmetic is modulo 2^64; accumulator overflow is impossible because |mag1*mag2| < 2^64.

Decomposition:
- Package mul_seq_pkg holds:
  - the op enum (MUL_OP_MUL/MULH/MULHSU/MULHU);
  - the state enum;
  - XLEN, CHUNK and NUM_STEPS constants;
  - the 2-bit op encoding shared with the decoder.
- One combinational sub-module, mul_seq_fin: inputs acc[63:0], neg and upper; output the 32-bit result word. It is reused wherever final sign correction and word select are needed.

Test Plan:
- MULHU 0xFFFFFFFF x 0xFFFFFFFF, RESP_READY=1 -> RESP_PROD=0xFFFFFFFE; RESP_VALID 4 cycles after accept; REQ_READY low throughout; tag echoed.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MUL 0x12345678 x 0x00000009 -> 0xA3D70A38.
- MULHSU 0xFFFFFFFF (rs1 = -1) x 0xFFFFFFFF (rs2 unsigned) -> 0xFFFFFFFF. MULH 0xFFFFFFFF x 0x00000001 -> 0xFFFFFFFF.
- MUL 0x00000000 x 0xDEADBEEF -> 0; RESP_VALID 1 cycle after accept via the zero fast path.
- Backpressure: hold RESP_READY=0 for 3 cycles after RESP_VALID -> RESP_PROD/RESP_TAG stable, REQ_READY=0; release -> RESP_VALID falls next edge, REQ_READY=1 the cycle after.
- FLUSH on 2nd ACCUM cycle -> no RESP_VALID ever; IDLE next cycle; a following MULHU 2 x 3 returns 0. Repeat with RST_N pulsed low mid-ACCUM -> all outputs 0 immediately; no response after release.
